// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared M-extension op codes, FSM states and decoded op flags
package muldiv_unit_pkg;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREP    = 3'd1,
        ST_CALC    = 3'd2,
        ST_FIN     = 3'd3,
        ST_SPECIAL = 3'd4
    } state_e;

    typedef struct packed {
        logic is_div;
        logic want_high;
        logic want_rem;
        logic signed_a;
        logic signed_b;
    } op_flags_t;

endpackage

// File: rtl/muldiv_op_decode.sv
// muldiv_op_decode: maps funct3 to operation class, result half and operand signedness
module muldiv_op_decode
    import muldiv_unit_pkg::*;
(
    input  logic [2:0] funct3_i,
    output op_flags_t  flags_o
);

    assign flags_o.is_div    = funct3_i[2];
    assign flags_o.want_high = funct3_i inside {MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU};
    assign flags_o.want_rem  = funct3_i inside {MULDIV_REM, MULDIV_REMU};
    assign flags_o.signed_a  = !(funct3_i inside {MULDIV_MULHU, MULDIV_DIVU, MULDIV_REMU});
    assign flags_o.signed_b  = !(funct3_i inside {MULDIV_MULHSU, MULDIV_MULHU, MULDIV_DIVU, MULDIV_REMU});

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension multiply/divide with start/busy/done handshake
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [XLEN-1:0] result
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, mc_q, mc_d, result_q, result_d;
    op_flags_t         fl_q, fl_d, fl_in;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic              done_q, done_d, illegal_q, illegal_d;

    logic              legal, div0, ovf, special, na, nb;
    logic [XLEN-1:0]   spec_val, a_abs, b_abs, quo, rem, fin_val;
    logic [XLEN:0]     sum, diff;
    logic [2*XLEN-1:0] prod, sprod;

    muldiv_op_decode u_dec (
        .funct3_i (funct3),
        .flags_o  (fl_in)
    );

    // Datapath: special-case detection, magnitudes, one shift-add/restoring step, final sign fix
    always_comb begin
        legal    = funct7 == FUNCT7_MEXT;
        div0     = op_b == '0;
        ovf      = fl_in.signed_a && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1;
        special  = fl_in.is_div && (div0 || ovf);
        spec_val = fl_in.want_rem ? (div0 ? op_a : '0) : (div0 ? '1 : op_a);
        na       = fl_q.signed_a && lo_q[XLEN-1];
        nb       = fl_q.signed_b && mc_q[XLEN-1];
        a_abs    = na ? -lo_q : lo_q;
        b_abs    = nb ? -mc_q : mc_q;
        sum      = {1'b0, hi_q} + {1'b0, lo_q[0] ? mc_q : '0};
        diff     = {hi_q, lo_q[XLEN-1]} - {1'b0, mc_q};
        prod     = {hi_q, lo_q};
        sprod    = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo      = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
        rem      = neg_a_q ? -hi_q : hi_q;
        fin_val  = fl_q.is_div ? (fl_q.want_rem ? rem : quo)
                               : (fl_q.want_high ? sprod[2*XLEN-1:XLEN] : sprod[XLEN-1:0]);
    end

    // Next state: accept in IDLE or in the done cycle, then PREP -> CALC x XLEN -> FIN
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mc_d      = mc_q;
        fl_d      = fl_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        result_d  = result_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (state_q == ST_FIN) result_d = fin_val;
                if (start && legal) begin
                    fl_d    = fl_in;
                    lo_d    = special ? spec_val : op_a;
                    mc_d    = op_b;
                    state_d = special ? ST_SPECIAL : ST_PREP;
                end else if (start) begin
                    illegal_d = 1'b1;
                end
            end
            ST_PREP: begin
                neg_a_d = na;
                neg_b_d = nb;
                hi_d    = '0;
                lo_d    = fl_q.is_div ? a_abs : b_abs;
                mc_d    = fl_q.is_div ? b_abs : a_abs;
                cnt_d   = '0;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                hi_d  = fl_q.is_div ? (diff[XLEN] ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : diff[XLEN-1:0])
                                    : sum[XLEN:1];
                lo_d  = fl_q.is_div ? {lo_q[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo_q[XLEN-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIN;
            end
            ST_SPECIAL: begin
                result_d = lo_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mc_q      <= '0;
            fl_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mc_q      <= mc_d;
            fl_q      <= fl_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            result_q  <= result_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy    = state_q inside {ST_PREP, ST_CALC, ST_SPECIAL};
    assign done    = state_q == ST_FIN || done_q;
    assign illegal = illegal_q;
    assign result  = state_q == ST_FIN ? fin_val : result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M/RV64M multiply/divide unit. It decodes funct3/funct7 of R-type M-extension instructions and computes the result over multiple cycles using a start/busy/done handshake. It sits beside the single-cycle ALU, and the core stalls on busy. It is the parametrised, sequential successor to the combinational ALU decode path: it adds the MUL/DIV op family, a configurable XLEN, and a multi-cycle datapath.

Parameters:
XLEN, 32, operand/result width in bits (32 or 64).
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request; sampled only when busy=0.
funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
funct7  in  7  must equal 7'b0000001 for a legal request.
op_a  in  XLEN  rs1 value (multiplicand/dividend).
op_b  in  XLEN  rs2 value (multiplier/divisor).
busy  out  1  high while an operation is in flight.
done  out  1  one-cycle pulse; result valid in the same cycle.
illegal  out  1  one-cycle pulse: start with funct7 != 0000001.
result  out  XLEN  result; held from done until the next accepted start.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, illegal=0, result=0; counter and internal registers cleared.
- rst asserted mid-operation: the unit returns to IDLE on that edge. No done is ever produced for the aborted operation, and result=0.
- States and transitions:
  - IDLE: start && legal -> PREP (or SPECIAL for div-by-zero/overflow).
  - IDLE: start && !legal -> stays IDLE; illegal=1 next cycle.
  - PREP: latch |a|, |b| and sign flags -> CALC, counter=0.
  - CALC: one iteration per cycle; leaves when counter==XLEN-1 -> FIN.
  - FIN: sign-correct, select half -> IDLE; done=1 and result valid in this cycle.
  - SPECIAL: -> IDLE with done=1.
- Latency, with the start edge as cycle 0:
  - Normal ops: busy=1 in cycles 1..XLEN+1; done=1 in cycle XLEN+2.
  - Special cases: done in cycle 2.
- busy falls in the same cycle done rises. A start in the done cycle is accepted, giving back-to-back ops.
- start while busy=1 is ignored; operands are not re-sampled.
- Operands and funct3 are latched at accept; later changes on the inputs have no effect.
- Multiply: shift-add over XLEN iterations on magnitudes into a 2*XLEN accumulator. The product is negated when sign(a)^sign(b) applies.
  - Signedness: MUL and MULH treat a and b as signed; MULHSU treats a as signed, b as unsigned; MULHU treats both as unsigned.
  - MUL returns the low XLEN bits; the MULH* ops return the high XLEN bits.
- Divide: restoring division over XLEN iterations on magnitudes. Quotient truncates toward zero; remainder takes the sign of the dividend. DIVU/REMU are fully unsigned.
- Divide by zero (op_b==0): SPECIAL path.
  - DIV/DIVU return all-ones.
  - REM/REMU return op_a.
- Signed overflow (DIV/REM with op_a=-2^(XLEN-1), op_b=-1): SPECIAL path.
  - DIV returns op_a.
  - REM returns 0.
- Width rule: all internal arithmetic is XLEN+1 bits (divide) or 2*XLEN bits (multiply). There is no truncation until FIN.
- done and illegal are never high in the same cycle.

Decomposition:
- Shared define header gets the following constants, added beside the existing ALUOp/ALU control codes:
  - funct3 codes (MULDIV_MUL .. MULDIV_REMU);
  - FUNCT7_MEXT = 7'b0000001;
  - state encodings (IDLE, PREP, CALC, FIN, SPECIAL).
- One combinational sub-module, muldiv_op_decode, maps funct3 to:
  - is_div, want_high, want_rem;
  - signed_a, signed_b.
- The top level holds the FSM, counter and datapath.

Test Plan (XLEN=32):
- MUL 7 x -3 (0xFFFFFFFD), start at cycle 0 -> done at cycle 34, result=0xFFFFFFEB; busy high in cycles 1..33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100%7 -> 2.
- DIV 100/0 -> 0xFFFFFFFF and REM 100%0 -> 100, each with done at cycle 2. DIV 0x80000000/-1 -> 0x80000000 and REM -> 0, each with done at cycle 2.
- Control cases:
  - start pulsed again at cycle 5 of a MUL -> ignored; the original result is unchanged.
  - start with funct7=0100000 -> illegal pulse in cycle 1, busy stays 0.
- Reset mid-operation: rst=1 at cycle 10 of a DIV -> busy=0, result=0 next cycle, and no done pulse ever. A fresh DIVU 9/3 afterwards -> 3.
